// File: rtl/execute_mc_if.sv
// execute_mc_if: instruction handshake, operand/result buses and debug read port of execute_mc
interface execute_mc_if #(parameter int DATA_W = 32);
    logic              instr_valid;
    logic [31:0]       instr;
    logic              instr_ready;
    logic [DATA_W-1:0] busA;
    logic [DATA_W-1:0] busB;
    logic [DATA_W-1:0] busW;
    logic              done;
    logic              illegal;
    logic              exc;
    logic [4:0]        dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    modport master (
        output instr_valid, instr, dbg_addr,
        input  instr_ready, busA, busB, busW, done, illegal, exc, dbg_data
    );
    modport slave (
        input  instr_valid, instr, dbg_addr,
        output instr_ready, busA, busB, busW, done, illegal, exc, dbg_data
    );
endinterface

// File: rtl/execute_mc.sv
// execute_mc: multi-cycle MIPS execute unit (IDLE/EXEC/MEM/WB) with register file and data memory;
// define EXEC_OVF_TRAP_EN to trap signed overflow of add/sub/addi and suppress the write.
module execute_mc #(
    parameter int DATA_W     = 32,
    parameter int NREGS      = 32,
    parameter int DMEM_DEPTH = 256
) (
    input logic         CLK,
    input logic         RST_N,
    execute_mc_if.slave bus
);
    localparam int RW = $clog2(NREGS);
    localparam int AW = $clog2(DMEM_DEPTH);
    typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;
    state_t            state, state_nx;
    logic [31:0]       ir;
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];
    logic [RW-1:0]     rs, rt, rd, dst, wr_dst, dbg_idx;
    logic [5:0]        op, fn;
    logic [4:0]        sh;
    logic [DATA_W-1:0] a, b, simm, zimm, sum, diff, sumi, res;
    logic              ill, trap, is_lw, is_sw, wen, wr_en;
    logic [AW-1:0]     maddr;
    assign op      = ir[31:26];
    assign rs      = RW'(ir[25:21]);
    assign rt      = RW'(ir[20:16]);
    assign rd      = RW'(ir[15:11]);
    assign sh      = ir[10:6];
    assign fn      = ir[5:0];
    assign simm    = {{(DATA_W-16){ir[15]}}, ir[15:0]};
    assign zimm    = {{(DATA_W-16){1'b0}}, ir[15:0]};
    assign a       = rs == '0 ? '0 : regs[rs];
    assign b       = rt == '0 ? '0 : regs[rt];
    assign sum     = a + b;
    assign diff    = a - b;
    assign sumi    = a + simm;
    assign is_lw   = op == 6'h23;
    assign is_sw   = op == 6'h2B;
    assign dbg_idx = RW'(bus.dbg_addr);
    assign bus.dbg_data    = dbg_idx == '0 ? '0 : regs[dbg_idx];
    assign bus.instr_ready = state == IDLE;
    assign bus.done        = state == WB;
    always_comb begin
        res = '0;
        ill = 1'b0;
        dst = rt;
        case (op)
            6'h00: begin
                dst = rd;
                case (fn)
                    6'h20:   res = sum;
                    6'h22:   res = diff;
                    6'h24:   res = a & b;
                    6'h25:   res = a | b;
                    6'h2A:   res = DATA_W'($signed(a) < $signed(b));
                    6'h00:   res = b << sh;
                    6'h02:   res = b >> sh;
                    default: ill = 1'b1;
                endcase
            end
            6'h08, 6'h23: res = sumi;
            6'h0C:        res = a & zimm;
            6'h0D:        res = a | zimm;
            6'h2B:        res = b;
            default:      ill = 1'b1;
        endcase
    end
`ifdef EXEC_OVF_TRAP_EN
    localparam int M = DATA_W - 1;
    assign trap = (op == 6'h00 && fn == 6'h20) ? (a[M] == b[M] && sum[M] != a[M]) :
                  (op == 6'h00 && fn == 6'h22) ? (a[M] != b[M] && diff[M] != a[M]) :
                  (op == 6'h08 && a[M] == simm[M] && sumi[M] != a[M]);
`else
    assign trap = 1'b0;
`endif
    assign wen = !ill && !is_sw && !trap;
    always_comb begin
        state_nx = state == IDLE ? (bus.instr_valid ? EXEC : IDLE) :
                   state == EXEC ? ((is_lw || is_sw) ? MEM : WB) :
                   state == MEM  ? WB : IDLE;
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nx;
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ir          <= '0;
            bus.busA    <= '0;
            bus.busB    <= '0;
            bus.busW    <= '0;
            bus.illegal <= 1'b0;
            bus.exc     <= 1'b0;
            wr_en       <= 1'b0;
            wr_dst      <= '0;
            maddr       <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (state == IDLE && bus.instr_valid) ir <= bus.instr;
            if (state == EXEC) begin
                bus.busA    <= a;
                bus.busB    <= b;
                bus.busW    <= res;
                bus.illegal <= ill;
                bus.exc     <= trap;
                wr_en       <= wen;
                wr_dst      <= dst;
                maddr       <= AW'(sumi >> 2);
            end
            if (state == MEM && is_lw) bus.busW <= dmem[maddr];
            if (state == WB && wr_en && wr_dst != '0) regs[wr_dst] <= bus.busW;
        end
    end
    // data memory keeps its contents across reset
    always_ff @(posedge CLK) begin
        if (state == MEM && is_sw) dmem[maddr] <= bus.busB;
    end
endmodule
